// File: rtl/axi4_slave_write_responder_pkg.sv
// Shared types for the AXI4 slave write responder and its burst address helper.
package axi4_slave_write_responder_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } awburst_e;

    typedef enum logic [2:0] {
        SIZE_1B   = 3'd0,
        SIZE_2B   = 3'd1,
        SIZE_4B   = 3'd2,
        SIZE_8B   = 3'd3,
        SIZE_16B  = 3'd4,
        SIZE_32B  = 3'd5,
        SIZE_64B  = 3'd6,
        SIZE_128B = 3'd7
    } awsize_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } bresp_e;

    typedef enum bit [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } axi4_slv_wr_state_e;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return len inside {8'd1, 8'd3, 8'd7, 8'd15};
    endfunction

endpackage

// File: rtl/axi4_slave_write_responder_if.sv
// AXI4 write channels (AW, W, B) bundled for master/slave connection.
interface axi4_slave_write_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 4
) ();
    logic [ID_WIDTH-1:0]      awid;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [7:0]               awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic                     awlock;
    logic                     awvalid;
    logic                     awready;

    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH/8-1:0]  wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;

    logic [ID_WIDTH-1:0]      bid;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Works from the current beat address only, so a read responder can reuse it.
module axi4_burst_addr_gen
    import axi4_slave_write_responder_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic [ADDRESS_WIDTH-1:0] i_addr,
    input  logic [7:0]               i_len,
    input  awsize_e                  i_size,
    input  awburst_e                 i_burst,
    output logic [ADDRESS_WIDTH-1:0] o_next_addr
);
    logic [ADDRESS_WIDTH-1:0] w_bytes;
    logic [ADDRESS_WIDTH-1:0] w_aligned;
    logic [ADDRESS_WIDTH-1:0] w_incr;
    logic [ADDRESS_WIDTH-1:0] w_total;
    logic [ADDRESS_WIDTH-1:0] w_wrap_mask;

    // Step to the next size-aligned beat; WRAP keeps the upper bits of the
    // wrap window (total is a power of two for legal wrap lengths).
    always_comb begin
        w_bytes     = ADDRESS_WIDTH'(1) << i_size;
        w_aligned   = i_addr & ~(w_bytes - ADDRESS_WIDTH'(1));
        w_incr      = w_aligned + w_bytes;
        w_total     = ADDRESS_WIDTH'({1'b0, i_len} + 9'd1) << i_size;
        w_wrap_mask = w_total - ADDRESS_WIDTH'(1);
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_INCR:  o_next_addr = w_incr;
            BURST_WRAP:  o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
            default:     o_next_addr = i_addr;
        endcase
    end
endmodule

// File: rtl/axi4_slave_write_responder.sv
// AXI4 slave write responder: one outstanding write, strobed bytes stored in a
// local byte memory, B returned with the captured AWID. Backdoor byte read port.
module axi4_slave_write_responder
    import axi4_slave_write_responder_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH   = 32,
    parameter int                       DATA_WIDTH      = 32,
    parameter int                       ID_WIDTH        = 4,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS    = '0,
    parameter int                       MEM_DEPTH_BYTES = 4096
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    axi4_slave_write_responder_if.slave  s_axi,
    input  logic [ADDRESS_WIDTH-1:0]     dbg_addr,
    output logic [7:0]                   dbg_rdata
);
    localparam int NB      = DATA_WIDTH / 8;
    localparam int NB_LOG2 = $clog2(NB);
    localparam int MEM_AW  = $clog2(MEM_DEPTH_BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] LANE_MASK = ADDRESS_WIDTH'(NB - 1);
    localparam logic [ADDRESS_WIDTH-1:0] DEPTH     = ADDRESS_WIDTH'(MEM_DEPTH_BYTES);

    axi4_slv_wr_state_e r_state, w_state_nxt;

    logic                     r_awready, r_wready, r_bvalid;
    bresp_e                   r_bresp, w_bresp_nxt;
    logic                     w_awready_nxt, w_wready_nxt, w_bvalid_nxt;

    logic [ID_WIDTH-1:0]      r_id;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [7:0]               r_len;
    awsize_e                  r_size;
    awburst_e                 r_burst;
    logic [7:0]               r_beat;
    logic                     r_err;
    logic                     r_nowr;

    logic [7:0]               r_mem [MEM_DEPTH_BYTES];

    logic                     w_aw_hs, w_beat, w_b_hs, w_last_beat;
    logic                     w_cfg_err, w_last_err, w_lane_err;
    logic [ADDRESS_WIDTH-1:0] w_next_addr;
    logic [ADDRESS_WIDTH-1:0] w_dbg_off;
    logic                     w_unused_lock;

    logic [NB-1:0][ADDRESS_WIDTH-1:0] w_lane_off;
    logic [NB-1:0]                    w_lane_in, w_lane_oor, w_lane_we;

    // Exclusive access has no monitor: awlock is accepted and ignored.
    assign w_unused_lock = s_axi.awlock;

    assign w_aw_hs     = s_axi.awvalid & r_awready;
    assign w_beat      = s_axi.wvalid & r_wready;
    assign w_b_hs      = r_bvalid & s_axi.bready;
    assign w_last_beat = (r_beat == r_len);

    // Burst shapes that cannot be served at all: consume beats, write nothing.
    assign w_cfg_err = (s_axi.awburst == BURST_RSVD)
                     | (s_axi.awsize > 3'(NB_LOG2))
                     | ((s_axi.awburst == BURST_WRAP) & ~wrap_len_ok(s_axi.awlen));

    assign w_last_err = w_beat & (s_axi.wlast != w_last_beat);
    assign w_lane_err = w_beat & (|w_lane_oor);

    axi4_burst_addr_gen #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_addr_gen (
        .i_addr      (r_addr),
        .i_len       (r_len),
        .i_size      (r_size),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    // Per-lane byte address relative to BASE; unsigned compare also rejects
    // addresses below BASE because the subtraction wraps.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign w_lane_off[gi] = (r_addr & ~LANE_MASK) + ADDRESS_WIDTH'(gi) - BASE_ADDRESS;
        assign w_lane_in[gi]  = (w_lane_off[gi] < DEPTH);
        assign w_lane_oor[gi] = s_axi.wstrb[gi] & ~w_lane_in[gi];
        assign w_lane_we[gi]  = w_beat & s_axi.wstrb[gi] & w_lane_in[gi] & ~r_nowr;
    end

    // FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= WR_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next state: awlen alone decides when the data phase ends
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WR_IDLE: if (w_aw_hs)               w_state_nxt = WR_DATA;
            WR_DATA: if (w_beat && w_last_beat) w_state_nxt = WR_RESP;
            WR_RESP: if (w_b_hs)                w_state_nxt = WR_IDLE;
            default:                            w_state_nxt = WR_IDLE;
        endcase
    end

    // FSM outputs, computed from the next state so the handshakes are registered
    always_comb begin
        w_awready_nxt = (w_state_nxt == WR_IDLE);
        w_wready_nxt  = (w_state_nxt == WR_DATA);
        w_bvalid_nxt  = (w_state_nxt == WR_RESP);
        w_bresp_nxt   = r_bresp;
        if (r_state == WR_DATA && w_state_nxt == WR_RESP)
            w_bresp_nxt = (r_err | w_lane_err | w_last_err) ? RESP_SLVERR : RESP_OKAY;
    end

    // Registered handshake outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
        end
    end

    // Burst context: captured on AW, advanced on every accepted beat
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= SIZE_1B;
            r_burst <= BURST_FIXED;
            r_beat  <= '0;
            r_err   <= 1'b0;
            r_nowr  <= 1'b0;
        end else if (w_aw_hs) begin
            r_id    <= s_axi.awid;
            r_addr  <= s_axi.awaddr;
            r_len   <= s_axi.awlen;
            r_size  <= awsize_e'(s_axi.awsize);
            r_burst <= awburst_e'(s_axi.awburst);
            r_beat  <= '0;
            r_err   <= w_cfg_err;
            r_nowr  <= w_cfg_err;
        end else if (w_beat) begin
            r_addr <= w_next_addr;
            r_beat <= r_beat + 8'd1;
            if (w_lane_err || w_last_err) r_err <= 1'b1;
        end
    end

    // Backing memory: no reset so contents survive aresetn
    always_ff @(posedge aclk) begin
        for (int i = 0; i < NB; i++) begin
            if (w_lane_we[i]) r_mem[w_lane_off[i][MEM_AW-1:0]] <= s_axi.wdata[8*i +: 8];
        end
    end

    assign w_dbg_off = dbg_addr - BASE_ADDRESS;
    assign dbg_rdata = (w_dbg_off < DEPTH) ? r_mem[w_dbg_off[MEM_AW-1:0]] : 8'h00;

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bid     = r_id;
    assign s_axi.bresp   = r_bresp;
endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Directed bench for axi4_slave_write_responder: expected B responses are queued
// when a burst is issued and popped when B appears; memory checked via dbg port.
module tb_axi4_slave_write_responder;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] dbg_addr;
    logic [7:0]  dbg_rdata;

    axi4_slave_write_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

    axi4_slave_write_responder #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4),
        .BASE_ADDRESS(32'h0), .MEM_DEPTH_BYTES(4096)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_axi     (bus),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed { logic [3:0] id; logic [1:0] resp; } exp_t;
    exp_t sb[$];

    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_byte(input logic [31:0] a, input logic [7:0] e, input string tag);
        dbg_addr = a;
        @(negedge aclk);
        chk($sformatf("%s_byte_%0h", tag, a), 64'(dbg_rdata), 64'(e));
    endtask

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic lock,
                            input string tag, output int t_hs);
        int n = 0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
        bus.awburst = burst; bus.awlock = lock; bus.awvalid = 1'b1;
        while (bus.awready !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) chk({tag, "_aw_timeout"}, 64'(n), 64'(0));
        chk({tag, "_wready_before_aw"}, 64'(bus.wready), 64'(0));
        tick();
        t_hs = cyc;
        bus.awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic last, input string tag);
        int n = 0;
        bus.wdata = d; bus.wstrb = s; bus.wlast = last; bus.wvalid = 1'b1;
        while (bus.wready !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) chk({tag, "_w_timeout"}, 64'(n), 64'(0));
        tick();
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic b_phase(input int t_hs, input int len, input int hold, input string tag);
        int   n = 0;
        exp_t e;
        while (bus.bvalid !== 1'b1 && n < 40) begin tick(); n++; end
        if (n >= 40) begin
            chk({tag, "_b_timeout"}, 64'(n), 64'(0));
        end else if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'(1));
        end else begin
            e = sb.pop_front();
            // first edge at which the master sees bvalid, relative to the AW handshake edge
            chk({tag, "_b_latency"}, 64'(cyc + 1 - t_hs), 64'(2 + len));
            for (int h = 0; h < hold; h++) begin
                tick();
                chk($sformatf("%s_hold%0d_bvalid", tag, h), 64'(bus.bvalid), 64'(1));
                chk($sformatf("%s_hold%0d_bid", tag, h), 64'(bus.bid), 64'(e.id));
            end
            chk({tag, "_bid"}, 64'(bus.bid), 64'(e.id));
            chk({tag, "_bresp"}, 64'(bus.bresp), 64'(e.resp));
            bus.bready = 1'b1;
            tick();
            bus.bready = 1'b0;
            chk({tag, "_bvalid_after_b"}, 64'(bus.bvalid), 64'(0));
            chk({tag, "_awready_after_b"}, 64'(bus.awready), 64'(1));
        end
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic lock,
                               input int last_at, input logic [1:0] resp, input int hold,
                               input string tag);
        int t_hs;
        sb.push_back({id, resp});
        aw_phase(id, addr, len, size, burst, lock, tag, t_hs);
        for (int k = 0; k <= int'(len); k++) w_beat(wd[k], ws[k], k == last_at, tag);
        b_phase(t_hs, int'(len), hold, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = 1'b0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        dbg_addr = '0;

        // reset state
        repeat (3) tick();
        chk("rst_awready", 64'(bus.awready), 64'(0));
        chk("rst_wready",  64'(bus.wready),  64'(0));
        chk("rst_bvalid",  64'(bus.bvalid),  64'(0));
        chk("rst_bid",     64'(bus.bid),     64'(0));
        chk("rst_bresp",   64'(bus.bresp),   64'(0));
        aresetn = 1'b1;
        tick();
        chk("awready_after_release", 64'(bus.awready), 64'(1));

        // 1: single INCR beat
        wd[0] = 32'hA1B2C3D4; ws[0] = 4'hF;
        write_burst(4'd3, 32'h10, 8'd0, 3'd2, INCR, 1'b0, 0, OKAY, 0, "t1");
        chk_byte(32'h10, 8'hD4, "t1"); chk_byte(32'h11, 8'hC3, "t1");
        chk_byte(32'h12, 8'hB2, "t1"); chk_byte(32'h13, 8'hA1, "t1");

        // known contents at 0x0 for the out-of-range aliasing check
        wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
        write_burst(4'd1, 32'h0, 8'd0, 3'd2, INCR, 1'b0, 0, OKAY, 0, "pre0");

        // 2: INCR x4 with wstrb=0x5 over a prefilled window, B held off 5 cycles
        for (int k = 0; k < 4; k++) begin wd[k] = 32'hEEEEEEEE; ws[k] = 4'hF; end
        write_burst(4'd2, 32'h100, 8'd3, 3'd2, INCR, 1'b0, 3, OKAY, 0, "pre2");
        wd[0] = 32'h03020100; wd[1] = 32'h13121110; wd[2] = 32'h23222120; wd[3] = 32'h33323130;
        for (int k = 0; k < 4; k++) ws[k] = 4'h5;
        write_burst(4'd5, 32'h100, 8'd3, 3'd2, INCR, 1'b0, 3, OKAY, 5, "t2");
        for (int a = 0; a < 16; a++) begin
            logic [7:0] e;
            e = (a % 2 == 1) ? 8'hEE : 8'(((a / 4) << 4) | (a % 4));
            chk_byte(32'h100 + 32'(a), e, "t2");
        end

        // 3: WRAP x4 from 0x38, then an illegal 3-beat WRAP
        for (int k = 0; k < 4; k++) begin wd[k] = {4{8'hA0 + 8'(k)}}; ws[k] = 4'hF; end
        write_burst(4'd6, 32'h38, 8'd3, 3'd2, WRAP, 1'b0, 3, OKAY, 0, "t3");
        chk_byte(32'h38, 8'hA0, "t3"); chk_byte(32'h3C, 8'hA1, "t3"); chk_byte(32'h3F, 8'hA1, "t3");
        chk_byte(32'h30, 8'hA2, "t3"); chk_byte(32'h33, 8'hA2, "t3"); chk_byte(32'h34, 8'hA3, "t3");
        for (int k = 0; k < 3; k++) begin wd[k] = 32'hFFFFFFFF; ws[k] = 4'hF; end
        write_burst(4'd7, 32'h30, 8'd2, 3'd2, WRAP, 1'b0, 2, SLVERR, 0, "t3bad");
        chk_byte(32'h30, 8'hA2, "t3bad"); chk_byte(32'h34, 8'hA3, "t3bad"); chk_byte(32'h38, 8'hA0, "t3bad");

        // 4: INCR crossing the top of memory, then FIXED overwrite
        wd[0] = 32'h11223344; wd[1] = 32'h55667788; ws[0] = 4'hF; ws[1] = 4'hF;
        write_burst(4'd8, 32'hFFC, 8'd1, 3'd2, INCR, 1'b0, 1, SLVERR, 0, "t4");
        chk_byte(32'hFFC, 8'h44, "t4"); chk_byte(32'hFFD, 8'h33, "t4");
        chk_byte(32'hFFE, 8'h22, "t4"); chk_byte(32'hFFF, 8'h11, "t4");
        chk_byte(32'h1000, 8'h00, "t4"); chk_byte(32'h000, 8'h0D, "t4"); chk_byte(32'h001, 8'hF0, "t4");
        wd[0] = 32'h01010101; wd[1] = 32'h02020202; wd[2] = 32'hCAFEBABE;
        for (int k = 0; k < 3; k++) ws[k] = 4'hF;
        write_burst(4'd9, 32'h20, 8'd2, 3'd2, FIXED, 1'b0, 2, OKAY, 0, "t4fix");
        chk_byte(32'h20, 8'hBE, "t4fix"); chk_byte(32'h21, 8'hBA, "t4fix");
        chk_byte(32'h22, 8'hFE, "t4fix"); chk_byte(32'h23, 8'hCA, "t4fix");

        // 5: early wlast, W before AW, reserved burst, oversize beat, awlock
        for (int k = 0; k < 4; k++) begin wd[k] = {4{8'h60 + 8'(k)}}; ws[k] = 4'hF; end
        write_burst(4'd10, 32'h60, 8'd3, 3'd2, INCR, 1'b0, 1, SLVERR, 0, "t5last");
        chk_byte(32'h6C, 8'h63, "t5last");

        bus.wdata = 32'h0; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t5_early_w%0d_wready", k), 64'(bus.wready), 64'(0));
        end
        bus.wvalid = 1'b0;

        wd[0] = 32'h0; ws[0] = 4'hF;
        write_burst(4'd11, 32'h10, 8'd0, 3'd2, RSVD, 1'b0, 0, SLVERR, 0, "t5rsvd");
        chk_byte(32'h10, 8'hD4, "t5rsvd"); chk_byte(32'h13, 8'hA1, "t5rsvd");
        write_burst(4'd12, 32'h10, 8'd0, 3'd3, INCR, 1'b0, 0, SLVERR, 0, "t5size");
        chk_byte(32'h10, 8'hD4, "t5size");
        wd[0] = 32'h76543210;
        write_burst(4'd13, 32'h80, 8'd0, 3'd2, INCR, 1'b1, 0, OKAY, 0, "t5lock");
        chk_byte(32'h80, 8'h10, "t5lock");

        // 6: reset in the middle of an 8-beat burst
        for (int k = 0; k < 8; k++) begin wd[k] = {4{8'h50 + 8'(k)}}; ws[k] = 4'hF; end
        aw_phase(4'd14, 32'h200, 8'd7, 3'd2, INCR, 1'b0, "t6", t);
        w_beat(wd[0], 4'hF, 1'b0, "t6");
        w_beat(wd[1], 4'hF, 1'b0, "t6");
        bus.wdata = wd[2]; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_awready", 64'(bus.awready), 64'(0));
        chk("t6_rst_wready",  64'(bus.wready),  64'(0));
        chk("t6_rst_bvalid",  64'(bus.bvalid),  64'(0));
        chk("t6_rst_bid",     64'(bus.bid),     64'(0));
        chk("t6_rst_bresp",   64'(bus.bresp),   64'(0));
        tick(); tick();
        bus.wvalid = 1'b0;
        aresetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t6_post%0d_bvalid", k), 64'(bus.bvalid), 64'(0));
            chk($sformatf("t6_post%0d_awready", k), 64'(bus.awready), 64'(1));
        end
        wd[0] = 32'h9ABCDEF0; ws[0] = 4'hF;
        write_burst(4'd15, 32'h300, 8'd0, 3'd2, INCR, 1'b0, 0, OKAY, 0, "t6next");
        chk_byte(32'h300, 8'hF0, "t6next");
        chk_byte(32'h200, 8'h50, "t6"); chk_byte(32'h204, 8'h51, "t6"); chk_byte(32'h207, 8'h51, "t6");

        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
